// File: rtl/w_fire_ctrl.sv
// rtl/w_fire_ctrl.sv - fire-geyser motion/animation controller, one update per VGA frame
module w_fire_ctrl #(
    parameter int START_X     = 400,
    parameter int TOP_Y       = 303,
    parameter int HIDE_Y      = 480,
    parameter int RISE_STEP   = 12,
    parameter int FALL_STEP   = 6,
    parameter int BURN_FRAMES = 90,
    parameter int IDLE_FRAMES = 120,
    parameter int ANIM_DIV    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       run,
    input  logic [3:0] scroll,
    output logic [9:0] posx,
    output logic [8:0] posy,
    output logic       animation_state,
    output logic       isplay
);

    typedef enum logic [1:0] {HIDDEN, RISING, BURNING, FALLING} state_t;

    state_t     r_state;
    logic [7:0] r_frame_cnt;
    logic [3:0] r_anim_cnt;
    logic       r_origin_q;
    logic [9:0] r_posx;
    logic [8:0] r_posy;
    logic       r_anim_state;
    logic       r_isplay;

    logic       w_origin;
    logic       w_tick;
    logic [9:0] w_posy10;
    logic [9:0] w_rise_y;
    logic [9:0] w_fall_y;
    logic       w_rise_sat;
    logic [9:0] w_scroll10;
    logic [9:0] w_posx_next;

    // Edge-detect the origin so a scan parked at (0,0) still yields one tick.
    assign w_origin = (x == 10'd0) && (y == 9'd0);
    assign w_tick   = w_origin & ~r_origin_q & run;

    assign w_posy10   = {1'b0, r_posy};
    assign w_rise_y   = w_posy10 - 10'(RISE_STEP);
    assign w_fall_y   = w_posy10 + 10'(FALL_STEP);
    assign w_rise_sat = (w_posy10 < 10'(RISE_STEP)) || (w_rise_y <= 10'(TOP_Y));

    // Wrap branch only taken when posx < scroll (<=15), so the sum stays below 655.
    assign w_scroll10  = {6'd0, scroll};
    assign w_posx_next = (r_posx >= w_scroll10) ? (r_posx - w_scroll10)
                                                : (r_posx + 10'd640 - w_scroll10);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HIDDEN;
            r_frame_cnt  <= 8'd0;
            r_anim_cnt   <= 4'd0;
            r_origin_q   <= 1'b0;
            r_posx       <= 10'(START_X);
            r_posy       <= 9'(HIDE_Y);
            r_anim_state <= 1'b0;
            r_isplay     <= 1'b0;
        end else begin
            r_origin_q <= w_origin;
            if (w_tick) begin
                r_posx <= w_posx_next;
                if (r_state != HIDDEN) begin
                    if (r_anim_cnt == 4'(ANIM_DIV - 1)) begin
                        r_anim_cnt   <= 4'd0;
                        r_anim_state <= ~r_anim_state;
                    end else begin
                        r_anim_cnt <= r_anim_cnt + 4'd1;
                    end
                end
                case (r_state)
                    HIDDEN: begin
                        r_posy <= 9'(HIDE_Y);
                        if (r_frame_cnt == 8'(IDLE_FRAMES - 1)) begin
                            r_state     <= RISING;
                            r_frame_cnt <= 8'd0;
                            r_isplay    <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                    RISING: begin
                        if (w_rise_sat) begin
                            r_posy      <= 9'(TOP_Y);
                            r_state     <= BURNING;
                            r_frame_cnt <= 8'd0;
                        end else begin
                            r_posy <= w_rise_y[8:0];
                        end
                    end
                    BURNING: begin
                        r_posy <= 9'(TOP_Y);
                        if (r_frame_cnt == 8'(BURN_FRAMES - 1)) begin
                            r_state     <= FALLING;
                            r_frame_cnt <= 8'd0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                    FALLING: begin
                        // Entering HIDDEN overrides the animation update above.
                        if (w_fall_y >= 10'(HIDE_Y)) begin
                            r_posy       <= 9'(HIDE_Y);
                            r_state      <= HIDDEN;
                            r_frame_cnt  <= 8'd0;
                            r_isplay     <= 1'b0;
                            r_anim_cnt   <= 4'd0;
                            r_anim_state <= 1'b0;
                        end else begin
                            r_posy <= w_fall_y[8:0];
                        end
                    end
                endcase
            end
        end
    end

    assign posx            = r_posx;
    assign posy            = r_posy;
    assign animation_state = r_anim_state;
    assign isplay          = r_isplay;

endmodule

// File: tb/tb_w_fire_ctrl.sv
// tb/tb_w_fire_ctrl.sv - scoreboard bench for w_fire_ctrl geyser cycle, scroll wrap, freeze, reset
module tb_w_fire_ctrl;

    localparam int STARTX = 400;
    localparam int TOPY   = 303;
    localparam int HIDEY  = 480;
    localparam int RISE   = 60;
    localparam int FALL   = 6;
    localparam int BURN   = 3;
    localparam int IDLE   = 2;
    localparam int DIV    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [8:0] y;
    logic       run;
    logic [3:0] scroll;
    logic [9:0] posx;
    logic [8:0] posy;
    logic       animation_state;
    logic       isplay;

    always #5 clk = ~clk;

    w_fire_ctrl #(
        .START_X(STARTX), .TOP_Y(TOPY), .HIDE_Y(HIDEY), .RISE_STEP(RISE),
        .FALL_STEP(FALL), .BURN_FRAMES(BURN), .IDLE_FRAMES(IDLE), .ANIM_DIV(DIV)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .run(run), .scroll(scroll),
        .posx(posx), .posy(posy), .animation_state(animation_state), .isplay(isplay)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [20:0] exp_q[$];
    logic [20:0] got;
    logic [20:0] exp_v;

    // Reference model: 0=hidden 1=rising 2=burning 3=falling
    int m_posx, m_posy, m_anim, m_vis, m_state, m_fc, m_ac;

    function automatic void model_reset();
        m_posx = STARTX; m_posy = HIDEY; m_anim = 0; m_vis = 0;
        m_state = 0; m_fc = 0; m_ac = 0;
    endfunction

    function automatic void model_tick(input int s);
        int st;
        st = m_state;
        if (st != 0) begin
            m_ac = m_ac + 1;
            if (m_ac == DIV) begin
                m_ac = 0;
                m_anim = 1 - m_anim;
            end
        end
        case (st)
            0: if (m_fc == IDLE - 1) begin m_state = 1; m_fc = 0; m_vis = 1; end
               else m_fc = m_fc + 1;
            1: if (m_posy - RISE <= TOPY) begin m_posy = TOPY; m_state = 2; m_fc = 0; end
               else m_posy = m_posy - RISE;
            2: if (m_fc == BURN - 1) begin m_state = 3; m_fc = 0; end
               else m_fc = m_fc + 1;
            default: if (m_posy + FALL >= HIDEY) begin
                         m_posy = HIDEY; m_state = 0; m_fc = 0;
                         m_vis = 0; m_ac = 0; m_anim = 0;
                     end else m_posy = m_posy + FALL;
        endcase
        if (m_posx >= s) m_posx = m_posx - s;
        else m_posx = m_posx + 640 - s;
    endfunction

    function automatic logic [20:0] model_pack();
        return {10'(m_posx), 9'(m_posy), 1'(m_anim), 1'(m_vis)};
    endfunction

    // One scan frame: origin held for `hold` clocks, then active video for a few clocks.
    task automatic run_frame(input logic r, input logic [3:0] s, input int hold);
        @(negedge clk);
        x = 10'd0; y = 9'd0; run = r; scroll = s;
        repeat (hold) @(negedge clk);
        x = 10'd100; y = 9'd50;
        if (r) model_tick(int'(s));
        exp_q.push_back(model_pack());
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; x = 10'd0; y = 9'd0; run = 1'b1; scroll = 4'd5;
        repeat (2) @(negedge clk);
        model_reset();
        n_checks++; if (posx !== 10'd400) begin n_fail++; $display("FAIL reset_posx got=%0d exp=400", posx); end
        n_checks++; if (posy !== 9'd480) begin n_fail++; $display("FAIL reset_posy got=%0d exp=480", posy); end
        n_checks++; if (isplay !== 1'b0) begin n_fail++; $display("FAIL reset_isplay got=%b exp=0", isplay); end
        n_checks++; if (animation_state !== 1'b0) begin n_fail++; $display("FAIL reset_anim got=%b exp=0", animation_state); end
        rst = 1'b0; x = 10'd100; y = 9'd50;
        repeat (2) @(negedge clk);
        got = {posx, posy, animation_state, isplay};
        exp_v = model_pack();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_held_origin();
        run_frame(1'b1, 4'd1, 4);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL held_origin_f1 got=%h exp=%h", got, exp_v); end
        run_frame(1'b1, 4'd1, 1);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL held_origin_f2 got=%h exp=%h", got, exp_v); end
        n_checks++; if (isplay !== 1'b1) begin n_fail++; $display("FAIL enter_rising_isplay got=%b exp=1", isplay); end
    endtask

    task automatic test_cycle();
        int rise_exp[3];
        int guard;
        rise_exp = '{420, 360, 303};
        for (int i = 0; i < 3; i++) begin
            run_frame(1'b1, 4'd0, 1);
            got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
            n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rise_frame%0d got=%h exp=%h", i, got, exp_v); end
            n_checks++; if (posy !== 9'(rise_exp[i])) begin n_fail++; $display("FAIL rise_posy%0d got=%0d exp=%0d", i, posy, rise_exp[i]); end
        end
        guard = 0;
        while (m_state != 0 && guard < 60) begin
            run_frame(1'b1, 4'd0, 1 + (guard % 2));
            got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
            n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL cycle_frame%0d got=%h exp=%h", guard, got, exp_v); end
            guard++;
        end
        n_checks++; if (guard >= 60) begin n_fail++; $display("FAIL cycle_timeout got=%0d exp<60", guard); end
        n_checks++; if (posy !== 9'd480) begin n_fail++; $display("FAIL hidden_posy got=%0d exp=480", posy); end
        n_checks++; if (isplay !== 1'b0) begin n_fail++; $display("FAIL hidden_isplay got=%b exp=0", isplay); end
        n_checks++; if (animation_state !== 1'b0) begin n_fail++; $display("FAIL hidden_anim got=%b exp=0", animation_state); end
    endtask

    task automatic test_scroll_wrap();
        int guard;
        guard = 0;
        while (m_posx > 20 && guard < 100) begin
            run_frame(1'b1, 4'd15, 1);
            got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
            n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL scroll_frame%0d got=%h exp=%h", guard, got, exp_v); end
            guard++;
        end
        run_frame(1'b1, 4'(m_posx - 5), 1);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL scroll_to5 got=%h exp=%h", got, exp_v); end
        n_checks++; if (posx !== 10'd5) begin n_fail++; $display("FAIL posx_5 got=%0d exp=5", posx); end
        run_frame(1'b1, 4'd8, 1);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL scroll_wrap got=%h exp=%h", got, exp_v); end
        n_checks++; if (posx !== 10'd637) begin n_fail++; $display("FAIL wrap_posx got=%0d exp=637", posx); end
        run_frame(1'b1, 4'd0, 1);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (posx !== 10'd637 || got !== exp_v) begin n_fail++; $display("FAIL scroll_zero got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 3; i++) begin
            run_frame(1'b0, 4'd9, 2);
            got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
            n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL freeze_frame%0d got=%h exp=%h", i, got, exp_v); end
        end
    endtask

    task automatic test_late_run();
        @(negedge clk);
        x = 10'd0; y = 9'd0; run = 1'b0; scroll = 4'd7;
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        x = 10'd100; y = 9'd50;
        exp_q.push_back(model_pack());
        repeat (3) @(negedge clk);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL late_run got=%h exp=%h", got, exp_v); end
        run_frame(1'b1, 4'd2, 1);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL after_late_run got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_reset_mid_fall();
        int guard;
        guard = 0;
        while (!(m_state == 3 && m_posy > TOPY) && guard < 80) begin
            run_frame(1'b1, 4'd3, 1);
            got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
            n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL prefall_frame%0d got=%h exp=%h", guard, got, exp_v); end
            guard++;
        end
        n_checks++; if (guard >= 80) begin n_fail++; $display("FAIL reach_falling_timeout got=%0d exp<80", guard); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        got = {posx, posy, animation_state, isplay}; exp_v = model_pack();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL reset_mid_fall got=%h exp=%h", got, exp_v); end
        run_frame(1'b1, 4'd3, 1);
        got = {posx, posy, animation_state, isplay}; exp_v = exp_q.pop_front();
        n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL post_reset_frame got=%h exp=%h", got, exp_v); end
    endtask

    initial begin
        test_reset();
        test_held_origin();
        test_cycle();
        test_scroll_wrap();
        test_freeze();
        test_late_run();
        test_reset_mid_fall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
